// File: rtl/elephant_pkg.sv
// Shared constants, FSM encoding and layer helpers for the Elephant-160 Spongent-pi[160] sequencer.
package elephant_pkg;

  localparam int STATE_W = 160;
  localparam int WORD_W  = 32;
  localparam int NWORDS  = 5;

  localparam logic [6:0] LFSR_INIT_DEF = 7'h75;
  localparam int         LFSR_TAP_HI   = 6;
  localparam int         LFSR_TAP_LO   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDC,
    S_SBOX,
    S_PLAY,
    S_DONE
  } fsm_e;

  // Destination bit of source bit j in the bit-permutation layer; the top bit is a fixed point.
  function automatic int perm_pos(input int j);
    int p;
    if (j == STATE_W - 1) p = j;
    else                  p = (j * 40) % (STATE_W - 1);
    return p;
  endfunction

  function automatic logic [6:0] bitrev7(input logic [6:0] v);
    logic [6:0] r;
    for (int k = 0; k < 7; k++) r[k] = v[6-k];
    return r;
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] v);
    return {v[5:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'hD;  4'h2: y = 4'hB;  4'h3: y = 4'h0;
      4'h4: y = 4'h2;  4'h5: y = 4'h1;  4'h6: y = 4'h4;  4'h7: y = 4'hF;
      4'h8: y = 4'h7;  4'h9: y = 4'hA;  4'hA: y = 4'h8;  4'hB: y = 4'h5;
      4'hC: y = 4'h9;  4'hD: y = 4'hC;  4'hE: y = 4'h3;  default: y = 4'h6;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/elephant_perm_ctrl_if.sv
// Valid/ready job interface of the permutation accelerator: state in, permuted state out, busy flag.
interface elephant_perm_ctrl_if;
  import elephant_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;
  logic               busy;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );

endinterface

// File: rtl/elephant_sbox_word.sv
// Combinational 32-bit S-box word unit: eight parallel 4-bit Spongent S-boxes.
module elephant_sbox_word
  import elephant_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word
);

  for (genvar n = 0; n < WORD_W / 4; n++) begin : g_nib
    assign o_word[4*n +: 4] = sbox4(i_word[4*n +: 4]);
  end

endmodule

// File: rtl/elephant_perm_ctrl.sv
// Spongent-pi[160] round sequencer (ADDC, SBOX, PLAY per round) with valid/ready on both sides.
// ELEPHANT_PERM_WIDE_SBOX_EN selects five S-box word units (3-cycle rounds) over one shared unit (7-cycle rounds).
module elephant_perm_ctrl
  import elephant_pkg::*;
#(
  parameter int         ROUNDS    = 80,
  parameter logic [6:0] LFSR_INIT = LFSR_INIT_DEF
) (
  input logic                 g_clk,
  input logic                 g_rst,
  elephant_perm_ctrl_if.slave bus
);

  fsm_e               r_fsm, w_fsm_nxt;
  logic [STATE_W-1:0] r_state, w_state_nxt, w_play;
  logic [6:0]         r_lfsr, w_lfsr_nxt;
  logic [6:0]         r_rnd, w_rnd_nxt;
  logic [2:0]         r_wi, w_wi_nxt;

`ifdef ELEPHANT_PERM_WIDE_SBOX_EN
  logic [STATE_W-1:0] w_sbox_all;

  for (genvar w = 0; w < NWORDS; w++) begin : g_sbox
    elephant_sbox_word u_sbox (
      .i_word (r_state[WORD_W*w +: WORD_W]),
      .o_word (w_sbox_all[WORD_W*w +: WORD_W])
    );
  end
`else
  logic [WORD_W-1:0] w_sbox_in, w_sbox_out;

  always_comb begin
    w_sbox_in = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (r_wi == 3'(k)) w_sbox_in = r_state[WORD_W*k +: WORD_W];
    end
  end

  elephant_sbox_word u_sbox (
    .i_word (w_sbox_in),
    .o_word (w_sbox_out)
  );
`endif

  // Bit-permutation layer is pure wiring.
  for (genvar j = 0; j < STATE_W; j++) begin : g_play
    localparam int P = perm_pos(j);
    assign w_play[P] = r_state[j];
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_lfsr  <= LFSR_INIT;
      r_rnd   <= '0;
      r_wi    <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_rnd   <= w_rnd_nxt;
      r_wi    <= w_wi_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_rnd_nxt   = r_rnd;
    w_wi_nxt    = r_wi;
    case (r_fsm)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = bus.in_state;
          w_lfsr_nxt  = LFSR_INIT;
          w_rnd_nxt   = '0;
          w_fsm_nxt   = S_ADDC;
        end
      end
      S_ADDC: begin
        w_state_nxt[6:0]           = r_state[6:0] ^ r_lfsr;
        w_state_nxt[STATE_W-1 -: 7] = r_state[STATE_W-1 -: 7] ^ bitrev7(r_lfsr);
        w_lfsr_nxt                 = lfsr_step(r_lfsr);
        w_wi_nxt                   = '0;
        w_fsm_nxt                  = S_SBOX;
      end
      S_SBOX: begin
`ifdef ELEPHANT_PERM_WIDE_SBOX_EN
        w_state_nxt = w_sbox_all;
        w_fsm_nxt   = S_PLAY;
`else
        for (int k = 0; k < NWORDS; k++) begin
          if (r_wi == 3'(k)) w_state_nxt[WORD_W*k +: WORD_W] = w_sbox_out;
        end
        w_wi_nxt = r_wi + 3'd1;
        if (r_wi == 3'(NWORDS - 1)) w_fsm_nxt = S_PLAY;
`endif
      end
      S_PLAY: begin
        w_state_nxt = w_play;
        w_rnd_nxt   = r_rnd + 7'd1;
        if (r_rnd == 7'(ROUNDS - 1)) w_fsm_nxt = S_DONE;
        else                         w_fsm_nxt = S_ADDC;
      end
      S_DONE: begin
        if (bus.out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (r_fsm == S_IDLE);
  assign bus.out_valid = (r_fsm == S_DONE);
  assign bus.busy      = (r_fsm != S_IDLE);
  assign bus.out_state = (r_fsm == S_DONE) ? r_state : '0;

endmodule

// File: tb/tb_elephant_perm_ctrl.sv
// Directed bench for elephant_perm_ctrl: an 80-round and a 1-round instance against a bit-level reference model.
module tb_elephant_perm_ctrl;

`ifdef ELEPHANT_PERM_WIDE_SBOX_EN
  localparam int CPR = 3;
`else
  localparam int CPR = 7;
`endif
  localparam int LIMIT = 2000;

  logic g_clk = 1'b0;
  logic g_rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] sb_tbl [0:15] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                                4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};

  elephant_perm_ctrl_if bus ();
  elephant_perm_ctrl_if bus1 ();

  elephant_perm_ctrl #(.ROUNDS(80)) u_dut (
    .g_clk (g_clk),
    .g_rst (g_rst),
    .bus   (bus.slave)
  );

  elephant_perm_ctrl #(.ROUNDS(1)) u_dut1 (
    .g_clk (g_clk),
    .g_rst (g_rst),
    .bus   (bus1.slave)
  );

  always #5 g_clk = ~g_clk;

  // Bit-serial reference: constant bits folded in from both ends, nibble-wise S-layer, bit-wise P-layer.
  function automatic logic [159:0] model(input logic [159:0] s_in, input int rounds);
    logic [159:0] s;
    logic [159:0] t;
    logic [6:0]   lf;
    s  = s_in;
    lf = 7'h75;
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < 7; k++) begin
        s[k]       = s[k] ^ lf[k];
        s[159 - k] = s[159 - k] ^ lf[k];
      end
      lf = {lf[5:0], lf[6] ^ lf[5]};
      for (int n = 0; n < 40; n++) s[4*n +: 4] = sb_tbl[s[4*n +: 4]];
      t      = '0;
      t[159] = s[159];
      for (int j = 0; j < 159; j++) t[(j * 40) % 159] = s[j];
      s = t;
    end
    return s;
  endfunction

  task automatic start_job(input logic [159:0] st);
    bus.in_valid = 1'b1;
    bus.in_state = st;
    @(posedge g_clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < LIMIT) begin
      @(posedge g_clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    g_rst = 1'b1;
    repeat (2) @(posedge g_clk);
    #1;
    g_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge g_clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready cyc %0d got %b exp 1", i, bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc %0d got %b exp 0", i, bus.out_valid); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc %0d got %b exp 0", i, bus.busy); end
      checks++;
      if (bus.out_state !== 160'h0) begin errors++; $display("FAIL reset_out_state cyc %0d got %h exp 0", i, bus.out_state); end
    end
  endtask

  task automatic test_zero_state();
    logic [159:0] exp_st;
    int cyc;
    exp_st = model(160'h0, 80);
    bus.out_ready = 1'b1;
    start_job(160'h0);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL zero_busy_start got %b exp 1", bus.busy); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready_run got %b exp 0", bus.in_ready); end
    wait_out(cyc);
    checks++;
    if (cyc !== 80 * CPR) begin errors++; $display("FAIL zero_latency got %0d exp %0d", cyc, 80 * CPR); end
    checks++;
    if (bus.out_state !== exp_st) begin errors++; $display("FAIL zero_result got %h exp %h", bus.out_state, exp_st); end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL zero_busy_done got %b exp 1", bus.busy); end
    @(posedge g_clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after_fire got %b exp 0", bus.busy); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid_after_fire got %b exp 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready_after_fire got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_known_vector();
    logic [159:0] st;
    logic [159:0] exp_st;
    int cyc;
    st     = 160'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEF;
    exp_st = model(st, 80);
    bus.out_ready = 1'b1;
    start_job(st);
    wait_out(cyc);
    checks++;
    if (cyc !== 80 * CPR) begin errors++; $display("FAIL known_latency got %0d exp %0d", cyc, 80 * CPR); end
    checks++;
    if (bus.out_state !== exp_st) begin errors++; $display("FAIL known_result got %h exp %h", bus.out_state, exp_st); end
    @(posedge g_clk); #1;
  endtask

  task automatic test_back_pressure();
    logic [159:0] st1;
    logic [159:0] st2;
    logic [159:0] exp1;
    logic [159:0] exp2;
    int cyc;
    st1  = 160'hCAFEBABE_00112233_44556677_8899AABB_CCDDEEFF;
    st2  = 160'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F_12345678;
    exp1 = model(st1, 80);
    exp2 = model(st2, 80);
    bus.out_ready = 1'b0;
    start_job(st1);
    wait_out(cyc);
    bus.in_valid = 1'b1;
    bus.in_state = st2;
    for (int i = 0; i < 50; i++) begin
      @(posedge g_clk); #1;
      checks++;
      if (bus.out_state !== exp1) begin errors++; $display("FAIL bp_hold_state cyc %0d got %h exp %h", i, bus.out_state, exp1); end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", i, bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b exp 1", i, bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    @(posedge g_clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_fire out_valid got %b exp 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_after_fire in_ready got %b exp 1", bus.in_ready); end
    @(posedge g_clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept busy got %b exp 1", bus.busy); end
    wait_out(cyc);
    checks++;
    if (cyc !== 80 * CPR) begin errors++; $display("FAIL bp_second_latency got %0d exp %0d", cyc, 80 * CPR); end
    checks++;
    if (bus.out_state !== exp2) begin errors++; $display("FAIL bp_second_result got %h exp %h", bus.out_state, exp2); end
    @(posedge g_clk); #1;
  endtask

  task automatic test_mid_reset();
    logic [159:0] exp_st;
    logic seen;
    int cyc;
    exp_st = model(160'h1, 80);
    bus.out_ready = 1'b1;
    start_job(160'hFFFF_0000_1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978);
    repeat (37 * CPR) @(posedge g_clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", bus.busy); end
    g_rst = 1'b1;
    @(posedge g_clk); #1;
    g_rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", bus.out_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    checks++;
    if (bus.out_state !== 160'h0) begin errors++; $display("FAIL midrst_out_state got %h exp 0", bus.out_state); end
    seen = 1'b0;
    repeat (80 * CPR) begin
      @(posedge g_clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_output got %b exp 0", seen); end
    start_job(160'h1);
    wait_out(cyc);
    checks++;
    if (cyc !== 80 * CPR) begin errors++; $display("FAIL midrst_fresh_latency got %0d exp %0d", cyc, 80 * CPR); end
    checks++;
    if (bus.out_state !== exp_st) begin errors++; $display("FAIL midrst_fresh_result got %h exp %h", bus.out_state, exp_st); end
    @(posedge g_clk); #1;
  endtask

  task automatic test_single_round();
    logic [159:0] exp_st;
    int cyc;
    exp_st = 160'hBFFFFFFF_FE3FFFFF_FFFE7FFF_FFFFFE40_00000003;
    bus1.out_ready = 1'b1;
    bus1.in_state  = 160'h0;
    bus1.in_valid  = 1'b1;
    @(posedge g_clk); #1;
    bus1.in_valid = 1'b0;
    cyc = 0;
    while (!bus1.out_valid && cyc < LIMIT) begin
      @(posedge g_clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== CPR) begin errors++; $display("FAIL one_round_latency got %0d exp %0d", cyc, CPR); end
    checks++;
    if (bus1.out_state !== exp_st) begin errors++; $display("FAIL one_round_result got %h exp %h", bus1.out_state, exp_st); end
    @(posedge g_clk); #1;
    checks++;
    if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL one_round_idle got %b exp 1", bus1.in_ready); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached, exp bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    g_rst          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_state   = '0;
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_state  = '0;
    bus1.out_ready = 1'b0;
    test_reset();
    test_zero_state();
    test_known_vector();
    test_back_pressure();
    test_mid_reset();
    test_single_round();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
